// File: rtl/brent_kung_addsub_pipe.sv
// rtl/brent_kung_addsub_pipe.sv - three-stage pipelined Brent-Kung adder/subtractor with valid/ready
module brent_kung_addsub_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int LOG2 = $clog2(WIDTH);

    logic             adv;
    logic             v1, v2, v3;
    logic [WIDTH-1:0] b, p0, g0;
    logic [WIDTH-1:0] p1, g1;
    logic             cin1;
    logic [WIDTH-1:0] gu, pu;
    logic [WIDTH-1:0] p2, gg2, pg2;
    logic             cin2;
    logic [WIDTH-1:0] gd;
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign adv       = ~v3 | out_ready;
    assign in_ready  = adv;
    assign out_valid = v3;

    always_comb begin
        b     = sub ? ~data2 : data2;
        p0    = data1 ^ b;
        g0    = data1 & b;
        g0[0] = g0[0] | (p0[0] & sub);
    end

    // Up-sweep: node i ends up holding the span ending at i whose length is the
    // largest power of two dividing i+1.
    always_comb begin
        gu = g1;
        pu = p1;
        for (int l = 1; l <= LOG2; l++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (((i + 1) % (1 << l)) == 0) begin
                    gu[i] = gu[i] | (pu[i] & gu[i - (1 << (l - 1))]);
                    pu[i] = pu[i] & pu[i - (1 << (l - 1))];
                end
            end
        end
    end

    // Down-sweep: grey cells extend the remaining spans down to bit 0.
    always_comb begin
        gd = gg2;
        for (int l = LOG2 - 1; l >= 1; l--) begin
            for (int i = 0; i < WIDTH; i++) begin
                if ((((i + 1) % (1 << l)) == 0) && (i + (1 << (l - 1)) < WIDTH)) begin
                    gd[i + (1 << (l - 1))] = gd[i + (1 << (l - 1))]
                                           | (pg2[i + (1 << (l - 1))] & gd[i]);
                end
            end
        end
        c = {gd, cin2};
        s = p2 ^ c[WIDTH-1:0];
    end

    // Group P of spans already anchored at bit 0 is never consumed downstream.
    logic unused_pg;
    assign unused_pg = ^pg2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            v3   <= 1'b0;
            p1   <= '0;
            g1   <= '0;
            cin1 <= 1'b0;
            p2   <= '0;
            gg2  <= '0;
            pg2  <= '0;
            cin2 <= 1'b0;
            res  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
            zero <= 1'b0;
        end else if (adv) begin
            v1   <= in_valid;
            v2   <= v1;
            v3   <= v2;
            p1   <= p0;
            g1   <= g0;
            cin1 <= sub;
            p2   <= p1;
            gg2  <= gu;
            pg2  <= pu;
            cin2 <= cin1;
            res  <= s;
            cout <= c[WIDTH];
            ovf  <= c[WIDTH] ^ c[WIDTH-1];
            zero <= ~|s;
        end
    end
endmodule

// File: tb/tb_brent_kung_addsub_pipe.sv
// tb/tb_brent_kung_addsub_pipe.sv - scoreboard bench for brent_kung_addsub_pipe
module tb_brent_kung_addsub_pipe;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         sub = 1'b0;
    logic [W-1:0] data1 = '0;
    logic [W-1:0] data2 = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] res;
    logic         cout, ovf, zero;

    always #5 clk = ~clk;

    brent_kung_addsub_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .sub(sub), .data1(data1), .data2(data2), .out_valid(out_valid),
        .out_ready(out_ready), .res(res), .cout(cout), .ovf(ovf), .zero(zero)
    );

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         v;
        logic         z;
        int           acc;
    } exp_t;

    exp_t         sb[$];
    int           n_chk = 0;
    int           n_fail = 0;
    int           cyc = 0;
    bit           lat_exact = 1'b1;
    bit           stalled_prev = 1'b0;
    logic [W+2:0] snap;
    logic [W-1:0] op_a[8];
    logic [W-1:0] op_b[8];
    logic         op_s[8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] bi, input logic s);
        exp_t         e;
        logic [W-1:0] bb;
        logic [W:0]   sum;
        bb    = s ? ~bi : bi;
        sum   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, s};
        e.r   = sum[W-1:0];
        e.c   = sum[W];
        e.v   = (a[W-1] == bb[W-1]) && (e.r[W-1] != a[W-1]);
        e.z   = (e.r == '0);
        e.acc = 0;
        return e;
    endfunction

    // One clock: sample away from the edge, score outputs, record acceptance.
    task automatic step(input logic ordy, output bit accepted);
        exp_t e;
        out_ready = ordy;
        @(negedge clk);
        if (out_valid && out_ready) begin
            check("result_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("res", 32'(res), 32'(e.r));
                check("cout", 32'(cout), 32'(e.c));
                check("ovf", 32'(ovf), 32'(e.v));
                check("zero", 32'(zero), 32'(e.z));
                if (lat_exact) check("latency", 32'(cyc - e.acc), 32'd3);
            end
        end
        if (out_valid && !out_ready) begin
            check("in_ready_stall", 32'(in_ready), 32'd0);
            if (stalled_prev) check("hold_stable", 32'({res, cout, ovf, zero}), 32'(snap));
            snap = {res, cout, ovf, zero};
            stalled_prev = 1'b1;
        end else begin
            stalled_prev = 1'b0;
        end
        accepted = in_valid && in_ready;
        if (accepted) begin
            e = model(data1, data2, sub);
            e.acc = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] bi, input logic s);
        bit acc = 1'b0;
        data1 = a; data2 = bi; sub = s; in_valid = 1'b1;
        for (int k = 0; k < 10 && !acc; k++) step(1'b1, acc);
        check("send_accepted", 32'(acc), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        for (int k = 0; k < 20 && sb.size() != 0; k++) step(1'b1, acc);
        check("drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        bit acc;
        int idx;

        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_outputs", 32'({res, cout, ovf, zero}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_rst", 32'(in_ready), 32'd1);

        send(16'd5000, 16'd3000, 1'b1);
        drain();
        send(16'd3000, 16'd5000, 1'b1);
        drain();
        send(16'h8000, 16'h0001, 1'b1);
        send(16'h7FFF, 16'h0001, 1'b0);
        drain();
        send(16'hFFFF, 16'h0001, 1'b0);
        drain();

        // Random stream with a 5-cycle downstream stall mid-stream.
        for (int i = 0; i < 8; i++) begin
            op_a[i] = 16'($urandom);
            op_b[i] = 16'($urandom);
            op_s[i] = 1'($urandom_range(0, 1));
        end
        lat_exact = 1'b0;
        idx = 0;
        for (int k = 0; k < 60 && idx < 8; k++) begin
            data1 = op_a[idx]; data2 = op_b[idx]; sub = op_s[idx]; in_valid = 1'b1;
            step(!(k >= 3 && k < 8), acc);
            if (acc) idx++;
        end
        in_valid = 1'b0;
        check("stream_all_sent", 32'(idx), 32'd8);
        drain();
        lat_exact = 1'b1;

        // Reset with three results in flight.
        data1 = 16'd10; data2 = 16'd3; sub = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(1'b1, acc);
            data1 = data1 + 16'd1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_outputs", 32'({res, cout, ovf, zero}), 32'd0);
        sb.delete();
        stalled_prev = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_mid_rst", 32'(in_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, acc);
            check("no_stale_valid", 32'(out_valid), 32'd0);
        end
        send(16'h1234, 16'h1234, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
